// File: rtl/axil_master_arbiter_if.sv
// AXI-Lite single-port bus bundle (AW/W/B/AR/R channels) shared by the
// arbiter (master side) and whatever slave sits behind it.
interface axil_if #(
    parameter int REG_WIDTH = 32
);
    logic [REG_WIDTH-1:0]   AWADDR;
    logic                   AWVALID;
    logic                   AWREADY;
    logic [REG_WIDTH-1:0]   WDATA;
    logic [REG_WIDTH/8-1:0] WSTRB;
    logic                   WVALID;
    logic                   WREADY;
    logic [1:0]             BRESP;
    logic                   BVALID;
    logic                   BREADY;
    logic [REG_WIDTH-1:0]   ARADDR;
    logic                   ARVALID;
    logic                   ARREADY;
    logic [REG_WIDTH-1:0]   RDATA;
    logic [1:0]             RRESP;
    logic                   RVALID;
    logic                   RREADY;

    modport master (
        output AWADDR, AWVALID, input AWREADY,
        output WDATA, WSTRB, WVALID, input WREADY,
        input  BRESP, BVALID, output BREADY,
        output ARADDR, ARVALID, input ARREADY,
        input  RDATA, RRESP, RVALID, output RREADY
    );

    modport slave (
        input  AWADDR, AWVALID, output AWREADY,
        input  WDATA, WSTRB, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input  ARADDR, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, input RREADY
    );
endinterface

// File: rtl/axil_master_arbiter.sv
// Two-requester round-robin arbiter that serialises single-beat read/write
// requests onto one AXI-Lite master port, one transaction in flight at a time.
module axil_master_arbiter #(
    parameter int REG_WIDTH = 32
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic [1:0]             REQ,
    input  logic [1:0]             REQ_WE,
    input  logic [2*REG_WIDTH-1:0] REQ_ADDR,
    input  logic [2*REG_WIDTH-1:0] REQ_WDATA,
    output logic [1:0]             ACK,
    output logic [REG_WIDTH-1:0]   RSP_RDATA,
    output logic                   RSP_ERR,
    output logic                   BUSY,
    output logic                   GNT_ID,
    axil_if.master                 m_axil
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        WR_RESP = 3'd2,
        RD      = 3'd3,
        RD_RESP = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t               state_reg, state_next;
    logic                 last_gnt_reg, last_gnt_next;
    logic                 gnt_id_reg, gnt_id_next;
    logic [REG_WIDTH-1:0] addr_reg, addr_next;
    logic [REG_WIDTH-1:0] wdata_reg, wdata_next;
    logic                 awvalid_reg, awvalid_next;
    logic                 wvalid_reg, wvalid_next;
    logic                 bready_reg, bready_next;
    logic                 arvalid_reg, arvalid_next;
    logic                 rready_reg, rready_next;
    logic [REG_WIDTH-1:0] rsp_rdata_reg, rsp_rdata_next;
    logic                 rsp_err_reg, rsp_err_next;

    logic [REG_WIDTH-1:0] req_addr  [2];
    logic [REG_WIDTH-1:0] req_wdata [2];
    logic                 winner;
    logic                 aw_pending;
    logic                 w_pending;
    logic                 unused_resp_bits;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign req_addr[gi]  = REQ_ADDR[gi*REG_WIDTH +: REG_WIDTH];
            assign req_wdata[gi] = REQ_WDATA[gi*REG_WIDTH +: REG_WIDTH];
            assign ACK[gi]       = (state_reg == DONE) && (gnt_id_reg == 1'(gi));
        end
    endgenerate

    // On contention the requester that did not win last time goes first.
    assign winner     = (REQ == 2'b11) ? ~last_gnt_reg : REQ[1];
    assign aw_pending = awvalid_reg && !m_axil.AWREADY;
    assign w_pending  = wvalid_reg && !m_axil.WREADY;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_reg     <= IDLE;
            last_gnt_reg  <= 1'b1;
            gnt_id_reg    <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            awvalid_reg   <= 1'b0;
            wvalid_reg    <= 1'b0;
            bready_reg    <= 1'b0;
            arvalid_reg   <= 1'b0;
            rready_reg    <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            last_gnt_reg  <= last_gnt_next;
            gnt_id_reg    <= gnt_id_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            awvalid_reg   <= awvalid_next;
            wvalid_reg    <= wvalid_next;
            bready_reg    <= bready_next;
            arvalid_reg   <= arvalid_next;
            rready_reg    <= rready_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_err_reg   <= rsp_err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (|REQ) state_next = REQ_WE[winner] ? WR : RD;
            WR:      if (!aw_pending && !w_pending) state_next = WR_RESP;
            WR_RESP: if (m_axil.BVALID && bready_reg) state_next = DONE;
            RD:      if (arvalid_reg && m_axil.ARREADY) state_next = RD_RESP;
            RD_RESP: if (m_axil.RVALID && rready_reg) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // All bus outputs are registered, so ready inputs never reach a VALID combinationally.
    always_comb begin
        last_gnt_next  = last_gnt_reg;
        gnt_id_next    = gnt_id_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        awvalid_next   = awvalid_reg;
        wvalid_next    = wvalid_reg;
        bready_next    = bready_reg;
        arvalid_next   = arvalid_reg;
        rready_next    = rready_reg;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_err_next   = rsp_err_reg;
        case (state_reg)
            IDLE: begin
                if (|REQ) begin
                    last_gnt_next = winner;
                    gnt_id_next   = winner;
                    addr_next     = req_addr[winner];
                    wdata_next    = req_wdata[winner];
                    if (REQ_WE[winner]) begin
                        awvalid_next = 1'b1;
                        wvalid_next  = 1'b1;
                    end else begin
                        arvalid_next = 1'b1;
                    end
                end
            end
            WR: begin
                awvalid_next = aw_pending;
                wvalid_next  = w_pending;
                if (!aw_pending && !w_pending) bready_next = 1'b1;
            end
            WR_RESP: begin
                if (m_axil.BVALID && bready_reg) begin
                    bready_next    = 1'b0;
                    rsp_err_next   = m_axil.BRESP[1];
                    rsp_rdata_next = '0;
                end
            end
            RD: begin
                if (arvalid_reg && m_axil.ARREADY) begin
                    arvalid_next = 1'b0;
                    rready_next  = 1'b1;
                end
            end
            RD_RESP: begin
                if (m_axil.RVALID && rready_reg) begin
                    rready_next    = 1'b0;
                    rsp_err_next   = m_axil.RRESP[1];
                    rsp_rdata_next = m_axil.RDATA;
                end
            end
            default: ;
        endcase
    end

    assign m_axil.AWADDR  = addr_reg;
    assign m_axil.AWVALID = awvalid_reg;
    assign m_axil.WDATA   = wdata_reg;
    assign m_axil.WSTRB   = '1;
    assign m_axil.WVALID  = wvalid_reg;
    assign m_axil.BREADY  = bready_reg;
    assign m_axil.ARADDR  = addr_reg;
    assign m_axil.ARVALID = arvalid_reg;
    assign m_axil.RREADY  = rready_reg;

    assign RSP_RDATA = rsp_rdata_reg;
    assign RSP_ERR   = rsp_err_reg;
    assign BUSY      = (state_reg != IDLE);
    assign GNT_ID    = gnt_id_reg;

    // Only the error bit of the response codes is reported.
    assign unused_resp_bits = m_axil.BRESP[0] ^ m_axil.RRESP[0];

endmodule

// File: tb/tb_axil_master_arbiter.sv
// Directed bench for axil_master_arbiter: hand-sequenced slave responses,
// cycle-exact checks sampled on the falling clock edge.
module tb_axil_master_arbiter;

    localparam int RW = 32;

    logic          ACLK;
    logic          ARESET;
    logic [1:0]    req;
    logic [1:0]    req_we;
    logic [2*RW-1:0] req_addr;
    logic [2*RW-1:0] req_wdata;
    logic [1:0]    ack;
    logic [RW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          busy;
    logic          gnt_id;

    int n_checks = 0;
    int n_fail   = 0;

    axil_if #(.REG_WIDTH(RW)) bus ();

    axil_master_arbiter #(.REG_WIDTH(RW)) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .REQ       (req),
        .REQ_WE    (req_we),
        .REQ_ADDR  (req_addr),
        .REQ_WDATA (req_wdata),
        .ACK       (ack),
        .RSP_RDATA (rsp_rdata),
        .RSP_ERR   (rsp_err),
        .BUSY      (busy),
        .GNT_ID    (gnt_id),
        .m_axil    (bus)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic log_txn(input string name);
        $display("txn %s: ack=%b gnt=%0d rdata=0x%08h err=%b", name, ack, gnt_id, rsp_rdata, rsp_err);
    endtask

    task automatic wait_ack(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge ACLK);
            if (ack != 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
        check("ack_timeout", 64'(ok), 64'd1);
    endtask

    initial begin
        logic ok;
        int   n;
        int   gap;
        int   acks;

        ARESET      = 1'b1;
        req         = '0;
        req_we      = '0;
        req_addr    = '0;
        req_wdata   = '0;
        bus.AWREADY = 1'b0;
        bus.WREADY  = 1'b0;
        bus.BRESP   = 2'b00;
        bus.BVALID  = 1'b0;
        bus.ARREADY = 1'b0;
        bus.RDATA   = '0;
        bus.RRESP   = 2'b00;
        bus.RVALID  = 1'b0;

        repeat (2) @(negedge ACLK);
        check("rst_awvalid", 64'(bus.AWVALID), 64'd0);
        check("rst_wvalid",  64'(bus.WVALID),  64'd0);
        check("rst_arvalid", 64'(bus.ARVALID), 64'd0);
        check("rst_bready",  64'(bus.BREADY),  64'd0);
        check("rst_rready",  64'(bus.RREADY),  64'd0);
        check("rst_ack",     64'(ack),         64'd0);
        check("rst_busy",    64'(busy),        64'd0);
        check("rst_gnt",     64'(gnt_id),      64'd0);
        check("rst_rdata",   64'(rsp_rdata),   64'd0);
        check("rst_err",     64'(rsp_err),     64'd0);
        check("rst_wstrb",   64'(bus.WSTRB),   64'hF);
        ARESET = 1'b0;

        // Single write from requester 0, slave always ready.
        req_addr[31:0]  = 32'h0000_0010;
        req_wdata[31:0] = 32'hDEAD_BEEF;
        req_we          = 2'b01;
        req             = 2'b01;
        bus.AWREADY     = 1'b1;
        bus.WREADY      = 1'b1;
        @(negedge ACLK);
        check("wr_awvalid", 64'(bus.AWVALID), 64'd1);
        check("wr_wvalid",  64'(bus.WVALID),  64'd1);
        check("wr_awaddr",  64'(bus.AWADDR),  64'h10);
        check("wr_wdata",   64'(bus.WDATA),   64'hDEAD_BEEF);
        check("wr_busy",    64'(busy),        64'd1);
        check("wr_gnt",     64'(gnt_id),      64'd0);
        check("wr_bready0", 64'(bus.BREADY),  64'd0);
        @(negedge ACLK);
        check("wr_awvalid_drop", 64'(bus.AWVALID), 64'd0);
        check("wr_wvalid_drop",  64'(bus.WVALID),  64'd0);
        check("wr_bready1",      64'(bus.BREADY),  64'd1);
        bus.AWREADY = 1'b0;
        bus.WREADY  = 1'b0;
        @(negedge ACLK);
        bus.BVALID = 1'b1;
        bus.BRESP  = 2'b00;
        @(negedge ACLK);
        bus.BVALID = 1'b0;
        check("wr_ack",       64'(ack),        64'b01);
        check("wr_err",       64'(rsp_err),    64'd0);
        check("wr_rdata",     64'(rsp_rdata),  64'd0);
        check("wr_bready_dn", 64'(bus.BREADY), 64'd0);
        log_txn("single_write");
        req = 2'b00;
        @(negedge ACLK);
        check("wr_ack_pulse", 64'(ack), 64'd0);

        // Read with error from requester 1, ARREADY held off.
        req_addr[63:32] = 32'h0000_0020;
        req_we          = 2'b00;
        req             = 2'b10;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            if (bus.ARVALID) n++;
            check("rd_araddr", 64'(bus.ARADDR), 64'h20);
            check("rd_rready0", 64'(bus.RREADY), 64'd0);
            if (i == 3) bus.ARREADY = 1'b1;
        end
        @(negedge ACLK);
        check("rd_arvalid_cycles", 64'(n), 64'd4);
        check("rd_arvalid_drop", 64'(bus.ARVALID), 64'd0);
        check("rd_rready1", 64'(bus.RREADY), 64'd1);
        bus.ARREADY = 1'b0;
        bus.RDATA   = 32'h1234_5678;
        bus.RRESP   = 2'b10;
        bus.RVALID  = 1'b1;
        @(negedge ACLK);
        bus.RVALID = 1'b0;
        check("rd_ack",    64'(ack),         64'b10);
        check("rd_rdata",  64'(rsp_rdata),   64'h1234_5678);
        check("rd_err",    64'(rsp_err),     64'd1);
        check("rd_gnt",    64'(gnt_id),      64'd1);
        check("rd_rready_dn", 64'(bus.RREADY), 64'd0);
        log_txn("read_err");
        req = 2'b00;
        @(negedge ACLK);
        check("rd_ack_pulse", 64'(ack), 64'd0);

        // Fairness: both requesting continuously.
        req_addr[31:0]  = 32'h0000_0100;
        req_addr[63:32] = 32'h0000_0200;
        req_we          = 2'b00;
        bus.ARREADY     = 1'b1;
        bus.RVALID      = 1'b1;
        bus.RRESP       = 2'b00;
        bus.RDATA       = 32'hCAFE_0000;
        req             = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_ack(20, ok);
            check("fair_ack", 64'(ack), (i % 2 == 0) ? 64'b01 : 64'b10);
            check("fair_gnt", 64'(gnt_id), 64'(i % 2));
            log_txn("fair_read");
            if (i == 3) req = 2'b00;
        end
        repeat (2) @(negedge ACLK);
        bus.ARREADY = 1'b0;
        bus.RVALID  = 1'b0;
        check("fair_idle", 64'(busy), 64'd0);

        // Split write handshake; write also clears the previous read data/error.
        req_addr[31:0]  = 32'h0000_0014;
        req_wdata[31:0] = 32'hA5A5_0001;
        req_we          = 2'b01;
        req             = 2'b01;
        @(negedge ACLK);
        check("sp_awvalid", 64'(bus.AWVALID), 64'd1);
        check("sp_wvalid",  64'(bus.WVALID),  64'd1);
        bus.AWREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            check("sp_awvalid_dn", 64'(bus.AWVALID), 64'd0);
            check("sp_wvalid_hold", 64'(bus.WVALID), 64'd1);
            check("sp_wdata", 64'(bus.WDATA), 64'hA5A5_0001);
            check("sp_bready0", 64'(bus.BREADY), 64'd0);
            if (i == 0) bus.AWREADY = 1'b0;
            if (i == 2) bus.WREADY = 1'b1;
        end
        @(negedge ACLK);
        check("sp_wvalid_dn", 64'(bus.WVALID), 64'd0);
        check("sp_bready1", 64'(bus.BREADY), 64'd1);
        bus.WREADY = 1'b0;
        bus.BVALID = 1'b1;
        bus.BRESP  = 2'b00;
        @(negedge ACLK);
        bus.BVALID = 1'b0;
        check("sp_ack",   64'(ack),       64'b01);
        check("sp_rdata", 64'(rsp_rdata), 64'd0);
        check("sp_err",   64'(rsp_err),   64'd0);
        log_txn("split_write");
        req = 2'b00;
        @(negedge ACLK);
        check("sp_ack_pulse", 64'(ack), 64'd0);

        // Back-to-back reads from requester 0.
        req_addr[31:0] = 32'h0000_0040;
        req_we         = 2'b00;
        bus.ARREADY    = 1'b1;
        bus.RVALID     = 1'b1;
        bus.RRESP      = 2'b00;
        req            = 2'b01;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            gap = 0;
            do begin
                @(negedge ACLK);
                gap++;
            end while (!bus.ARVALID && gap < 20);
            check("b2b_arvalid_seen", 64'(bus.ARVALID), 64'd1);
            if (i > 0) check("b2b_gap", 64'(gap), 64'd2);
            bus.RDATA = 32'h0000_1000 + 32'(i);
            wait_ack(20, ok);
            if (ok) acks++;
            check("b2b_ack", 64'(ack), 64'b01);
            check("b2b_rdata", 64'(rsp_rdata), 64'h1000 + 64'(i));
            log_txn("b2b_read");
            if (i == 2) req = 2'b00;
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge ACLK);
            if (ack != 2'b00) acks++;
        end
        check("b2b_ack_count", 64'(acks), 64'd3);
        bus.ARREADY = 1'b0;
        bus.RVALID  = 1'b0;

        // Reset in the middle of a stalled write from requester 0.
        req_addr[31:0]  = 32'h0000_0080;
        req_wdata[31:0] = 32'h0000_0055;
        req_we          = 2'b01;
        req             = 2'b01;
        @(negedge ACLK);
        check("rm_wvalid_pre", 64'(bus.WVALID), 64'd1);
        #2 ARESET = 1'b1;
        #1;
        check("rm_wvalid",  64'(bus.WVALID),  64'd0);
        check("rm_awvalid", 64'(bus.AWVALID), 64'd0);
        check("rm_bready",  64'(bus.BREADY),  64'd0);
        check("rm_busy",    64'(busy),        64'd0);
        check("rm_ack",     64'(ack),         64'd0);
        req = 2'b00;
        @(negedge ACLK);
        ARESET = 1'b0;
        check("rm_ack_after", 64'(ack), 64'd0);
        req_addr[31:0]  = 32'h0000_0090;
        req_addr[63:32] = 32'h0000_00A0;
        req_we          = 2'b00;
        bus.ARREADY     = 1'b1;
        bus.RVALID      = 1'b1;
        bus.RDATA       = 32'h0000_0077;
        req             = 2'b11;
        @(negedge ACLK);
        check("rm_first_araddr", 64'(bus.ARADDR), 64'h90);
        check("rm_first_gnt", 64'(gnt_id), 64'd0);
        wait_ack(20, ok);
        check("rm_first_ack", 64'(ack), 64'b01);
        log_txn("post_reset_read");
        req = 2'b00;
        repeat (3) @(negedge ACLK);
        bus.ARREADY = 1'b0;
        bus.RVALID  = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axil_master_arbiter.md
Name: axil_master_arbiter

Overview:
Two-requester round-robin arbiter and transaction sequencer that owns one AXI-Lite master port (AW/W/B/AR/R). It accepts single-beat read or write requests from two internal modules and serialises them onto the bus, one outstanding transaction at a time. It returns read data, a response error flag and a one-cycle completion ACK to the granted requester.

Parameters:
REG_WIDTH, 32, width of every address and data bus, including the AXI-Lite address and data.

Ports:
ACLK  in  1  clock; all logic on the rising edge
ARESET  in  1  asynchronous reset, active-high
REQ  in  2  per-requester request; held high until that requester's ACK
REQ_WE  in  2  per-requester 1 = write, 0 = read; valid while REQ is high
REQ_ADDR  in  2*REG_WIDTH  requester i address at [i*REG_WIDTH +: REG_WIDTH]
REQ_WDATA  in  2*REG_WIDTH  requester i write data, same packing
ACK  out  2  one-cycle completion pulse, one-hot to the granted requester
RSP_RDATA  out  REG_WIDTH  read data of the last completed read; 0 after a write
RSP_ERR  out  1  bit[1] of BRESP/RRESP of the last completed transaction
BUSY  out  1  high in every state except IDLE
GNT_ID  out  1  index of the current or last granted requester
AWADDR  out  REG_WIDTH  write address
AWVALID  out  1  write address valid
AWREADY  in  1  write address ready
WDATA  out  REG_WIDTH  write data
WSTRB  out  REG_WIDTH/8  write strobe; constant all-ones
WVALID  out  1  write data valid
WREADY  in  1  write data ready
BRESP  in  2  write response
BVALID  in  1  write response valid
BREADY  out  1  write response ready
ARADDR  out  REG_WIDTH  read address
ARVALID  out  1  read address valid
ARREADY  in  1  read address ready
RDATA  in  REG_WIDTH  read data
RRESP  in  2  read response
RVALID  in  1  read data valid
RREADY  out  1  read data ready

Behaviour:
- Reset (async, ARESET=1): all outputs 0 except WSTRB; FSM goes to IDLE; the round-robin pointer last_gnt is set to 1, so requester 0 wins first.
- FSM states: IDLE, WR, WR_RESP, RD, RD_RESP, DONE.
- IDLE: REQ is sampled only in this state. If any bit is set, grant one requester:
  - Both set: the winner is the requester not equal to last_gnt. Otherwise the single requester wins.
  - At grant, update last_gnt and GNT_ID, and latch the winner's address, data and WE into registers.
  - Write: next state WR; AWVALID and WVALID both rise in the same cycle, 1 cycle after REQ is sampled.
  - Read: next state RD; ARVALID rises 1 cycle after REQ is sampled.
- WR: AWVALID drops on the edge where AWVALID&&AWREADY; WVALID drops independently on the edge where WVALID&&WREADY. Either may complete first or both together. AWADDR/WDATA stay stable while their valid is high. Once both have completed, go to WR_RESP with BREADY=1 in that state.
- WR_RESP: on BVALID&&BREADY, drop BREADY, set RSP_ERR=BRESP[1], set RSP_RDATA=0, go to DONE.
- RD: ARVALID holds until ARVALID&&ARREADY, then drops; go to RD_RESP with RREADY=1.
- RD_RESP: on RVALID&&RREADY, drop RREADY, capture RSP_RDATA=RDATA and RSP_ERR=RRESP[1], go to DONE.
- DONE: ACK[GNT_ID]=1 for exactly this one cycle, then IDLE.
- Requester contract: REQ is cleared on the edge where ACK is sampled high. IDLE samples REQ one edge later, so there is no double grant.
- Back-to-back: the minimum gap between ACK and the next VALID is 2 cycles (DONE→IDLE→VALID).
- Ready signals already high when VALID rises complete the handshake in one cycle; there is no combinational path from a ready input to a VALID output.
- Request changes (REQ, address, data) while BUSY are ignored; the latched copy is used.
- RSP_RDATA and RSP_ERR hold their values until the next completion.
- No timeout: the FSM waits indefinitely for slave handshakes.
- ARESET mid-transaction: all VALID/READY signals drop immediately, no ACK is issued, and the pending transaction is abandoned.

Test Plan:
- Single write: req0 writes addr 0x10, data 0xDEADBEEF; AWREADY and WREADY tied 1; BVALID returned 2 cycles later with BRESP=0. Required: AWVALID/WVALID high 1 cycle with those values, ACK=2'b01 for 1 cycle, RSP_ERR=0, RSP_RDATA=0.
- Split write handshake: AWREADY at cycle+1, WREADY at cycle+4. Required: AWVALID drops after cycle+1, WVALID held with data stable until cycle+4, BREADY rises only after both complete.
- Read with error: req1 reads addr 0x20; ARREADY delayed 3 cycles; RVALID returns RDATA=0x12345678, RRESP=2'b10. Required: ARVALID held 4 cycles, RSP_RDATA=0x12345678, RSP_ERR=1, ACK=2'b10.
- Fairness: REQ=2'b11 held continuously with each requester re-requesting after its ACK. Required: grant order 0,1,0,1 and GNT_ID alternates.
- Back-to-back: a single requester issues 3 reads. Required: exactly one ACK per transaction and a 2-cycle ACK→ARVALID gap.
- Reset mid-transfer: ARESET pulsed while WVALID is high and WREADY=0. Required: all VALID/READY = 0 asynchronously, no ACK, the next request after reset is granted to requester 0.
